// File: rtl/rca_4_pkg.sv
// rca_4_pkg -- shared constants for the registered ripple-carry adder.
//   RCA_WIDTH  : default operand/sum width
//   RST_*      : values the output register takes while rst is asserted
package rca_4_pkg;

  localparam int   RCA_WIDTH = 4;

  // Reset image of the output register: empty sum, no carry, no overflow,
  // and a zero flag that is consistent with the all-zero sum.
  localparam logic RST_S_BIT = 1'b0;
  localparam logic RST_COUT  = 1'b0;
  localparam logic RST_V     = 1'b0;
  localparam logic RST_Z     = 1'b1;

endpackage : rca_4_pkg

// File: rtl/rca_4_full_adder.sv
// full_adder -- one purely combinational ripple stage.
//   a, b : addend bits
//   cin  : carry from the previous stage
//   s    : sum bit
//   cout : carry into the next stage
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic prop_s;

  assign prop_s = a ^ b;
  assign s      = prop_s ^ cin;
  // Generate when both bits are set, otherwise propagate the incoming carry.
  assign cout   = (a & b) | (cin & prop_s);

endmodule : full_adder

// File: rtl/rca_4.sv
// rca_4 -- WIDTH-bit ripple-carry adder with registered result and flags.
//   clk  : rising-edge clock for all state
//   rst  : asynchronous active-high reset of the output register
//   A, B : unsigned addends
//   Cin  : carry-in (weight 1)
//   S    : registered sum bits
//   Cout : registered carry-out (weight 2^WIDTH)
//   V    : registered two's-complement overflow flag
//   Z    : registered zero flag (S all zeros, Cout ignored)
// Result latency is one cycle; a new result is produced every cycle.
module rca_4
  import rca_4_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             Z
);

  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] sum_s;
  logic             ovf_s;
  logic             zero_s;

  logic [WIDTH-1:0] s_r;
  logic             cout_r;
  logic             v_r;
  logic             z_r;

  assign carry_s[0] = Cin;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_stage
      full_adder u_fa (
        .a    (A[gi]),
        .b    (B[gi]),
        .cin  (carry_s[gi]),
        .s    (sum_s[gi]),
        .cout (carry_s[gi+1])
      );
    end
  endgenerate

  // Signed overflow shows up as disagreement between the carries into and
  // out of the sign stage.
  assign ovf_s  = carry_s[WIDTH] ^ carry_s[WIDTH-1];
  assign zero_s = ~|sum_s;

  // Output register: async reset to the reset image, else capture this cycle's result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_r    <= {WIDTH{RST_S_BIT}};
      cout_r <= RST_COUT;
      v_r    <= RST_V;
      z_r    <= RST_Z;
    end else begin
      s_r    <= sum_s;
      cout_r <= carry_s[WIDTH];
      v_r    <= ovf_s;
      z_r    <= zero_s;
    end
  end

  assign S    = s_r;
  assign Cout = cout_r;
  assign V    = v_r;
  assign Z    = z_r;

endmodule : rca_4

// File: tb/tb_rca_4.sv
// tb_rca_4 -- directed, self-checking bench for rca_4 (WIDTH=4).
module tb_rca_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] S;
  logic       Cout;
  logic       V;
  logic       Z;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rca_4 #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .S    (S),
    .Cout (Cout),
    .V    (V),
    .Z    (Z)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] s, input logic co,
                            input logic v, input logic z);
    check({tag, ".S"},    {4'h0, S},    {4'h0, s});
    check({tag, ".Cout"}, {7'h0, Cout}, {7'h0, co});
    check({tag, ".V"},    {7'h0, V},    {7'h0, v});
    check({tag, ".Z"},    {7'h0, Z},    {7'h0, z});
  endtask

  // Drive one vector away from the edge, then sample just after the edge.
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic c);
    @(negedge clk);
    A = a; B = b; Cin = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] full;
    logic       vref;
    logic [3:0] ea;
    logic [3:0] eb;
    logic       ec;
    int         idx;

    // Reset with A=3,B=4,Cin=1: outputs forced before any clock edge.
    rst = 1'b1; A = 4'd3; B = 4'd4; Cin = 1'b1;
    #2;
    expect_out("rst_immediate", 4'b0000, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    expect_out("rst_held_over_edge", 4'b0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    expect_out("rst_release", 4'b1000, 1'b0, 1'b1, 1'b0);

    // Outputs hold while inputs move between edges.
    step(4'd5, 4'd6, 1'b0);
    expect_out("5p6", 4'b1011, 1'b0, 1'b1, 1'b0);
    A = 4'd0; B = 4'd0; Cin = 1'b0;
    #2;
    expect_out("hold", 4'b1011, 1'b0, 1'b1, 1'b0);

    // Mid-operation reset discards the held result immediately.
    step(4'd9, 4'd9, 1'b1);
    expect_out("9p9p1", 4'b0011, 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    expect_out("rst_mid", 4'b0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0; A = 4'd2; B = 4'd1; Cin = 1'b0;
    @(posedge clk); #1;
    expect_out("after_mid_rst", 4'b0011, 1'b0, 1'b0, 1'b0);

    // Sweeps A=B, one value per cycle.
    for (int a = 0; a < 16; a++) begin
      step(a[3:0], a[3:0], 1'b0);
      check("sweep0.S",    {4'h0, S},    8'((2 * a) % 16));
      check("sweep0.Cout", {7'h0, Cout}, {7'h0, (a >= 8)});
    end
    for (int a = 0; a < 16; a++) begin
      step(a[3:0], a[3:0], 1'b1);
      check("sweep1.S",    {4'h0, S},    8'((2 * a + 1) % 16));
      check("sweep1.Cout", {7'h0, Cout}, {7'h0, (a >= 8)});
    end
    expect_out("15p15p1", 4'b1111, 1'b1, 1'b0, 1'b0);

    // Boundary vectors.
    step(4'd8, 4'd8, 1'b0);
    expect_out("8p8", 4'b0000, 1'b1, 1'b1, 1'b1);
    step(4'd15, 4'd0, 1'b1);
    expect_out("15p0p1", 4'b0000, 1'b1, 1'b0, 1'b1);
    step(4'd7, 4'd0, 1'b1);
    expect_out("7p0p1", 4'b1000, 1'b0, 1'b1, 1'b0);
    step(4'd0, 4'd0, 1'b0);
    expect_out("zero", 4'b0000, 1'b0, 1'b0, 1'b1);

    // All 512 combinations in a scrambled order against a reference sum.
    for (int i = 0; i < 512; i++) begin
      idx = (i * 197 + 31) % 512;
      ea  = idx[3:0];
      eb  = idx[7:4];
      ec  = idx[8];
      step(ea, eb, ec);
      full = {1'b0, ea} + {1'b0, eb} + {4'h0, ec};
      vref = (ea[3] == eb[3]) && (full[3] != ea[3]);
      expect_out("exh", full[3:0], full[4], vref, (full[3:0] == 4'h0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rca_4
